// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load controller.
package imem_load_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD  = 4;
  localparam int TIMEOUT_CYC_DEF = 100000;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Single-port instruction RAM write/read port driven by the load controller.
interface imem_load_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_we;

  modport master (output imem_addr, output imem_wdata, output imem_we);
  modport slave  (input  imem_addr, input  imem_wdata, input  imem_we);
endinterface

// File: rtl/imem_load_ctrl_rx_word_packer.sv
// Packs UART bytes MSB-first into 32-bit words; pulses word_valid on the last byte.
module rx_word_packer
  import imem_load_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [1:0]  idx
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      idx_q <= '0;
    end else if (en && byte_vld) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  // data path carries no reset; contents are only observed after a full word
  always_ff @(posedge clock) begin
    if (en && byte_vld) begin
      word_q <= {word_q[23:0], byte_in};
    end
  end

  assign word       = word_q;
  assign idx        = idx_q;
  assign word_valid = en && byte_vld && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_load_ctrl.sv
// Shares the instruction RAM port between CPU fetch and a UART program loader,
// holding the CPU in reset while a load is in progress.
module imem_load_ctrl
  import imem_load_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       fetch_pc,
  input  logic              load_start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  imem_load_ctrl_if.master  imem,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded,
  output logic              fetch_oob
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wa_q, wa_d;
  logic [ADDR_W:0]     wl_q, wl_d;
  logic [CNT_W-1:0]    to_q, to_d;
  logic                started_q, started_d;
  logic                err_q, err_d;

  logic                pk_clr, pk_en, pk_word_valid;
  logic [31:0]         pk_word;
  logic [1:0]          pk_idx;
  logic                unused_pc_bits;

  assign pk_en  = (state_q == LOAD) || (state_q == COMMIT);
  assign pk_clr = (state_q == RUN) && load_start;

  rx_word_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clr        (pk_clr),
    .en         (pk_en),
    .byte_vld   (rx_valid),
    .byte_in    (rx_byte),
    .word       (pk_word),
    .word_valid (pk_word_valid),
    .idx        (pk_idx)
  );

  always_comb begin
    state_d   = state_q;
    wa_d      = wa_q;
    wl_d      = wl_q;
    to_d      = to_q;
    started_d = started_q;
    err_d     = err_q;
    unique case (state_q)
      RUN: begin
        if (load_start) begin
          state_d   = LOAD;
          wa_d      = '0;
          wl_d      = '0;
          to_d      = '0;
          started_d = 1'b0;
          err_d     = 1'b0;
        end
      end
      LOAD: begin
        // a byte always beats an expiring timeout
        if (rx_valid) begin
          to_d      = '0;
          started_d = 1'b1;
          if (pk_word_valid) state_d = COMMIT;
        end else if (started_q) begin
          if (to_q >= TO_LAST) begin
            state_d = DONE;
            if (pk_idx != 2'd0) err_d = 1'b1;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end
      COMMIT: begin
        wa_d = wa_q + 1'b1;
        wl_d = wl_q + 1'b1;
        to_d = rx_valid ? '0 : to_q + 1'b1;
        if (wa_q == '1) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = LOAD;
        end
      end
      DONE: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      wa_q      <= '0;
      wl_q      <= '0;
      to_q      <= '0;
      started_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wa_q      <= wa_d;
      wl_q      <= wl_d;
      to_q      <= to_d;
      started_q <= started_d;
      err_q     <= err_d;
    end
  end

  assign imem.imem_addr  = (state_q == RUN) ? fetch_pc[ADDR_W+1:2] : wa_q;
  assign imem.imem_we    = (state_q == COMMIT);
  assign imem.imem_wdata = (state_q == COMMIT) ? pk_word : 32'd0;

  assign cpu_hold       = (state_q != RUN);
  assign load_done      = (state_q == DONE);
  assign load_err       = err_q;
  assign words_loaded   = wl_q;
  assign fetch_oob      = (state_q == RUN) && (fetch_pc[31:ADDR_W+2] != '0);
  assign unused_pc_bits = ^fetch_pc[1:0];

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: two builds (ADDR_W=14 and ADDR_W=2) share one stimulus stream.
module tb_imem_load_ctrl;

  localparam int T = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_pc = 32'd0;
  logic        load_start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'd0;

  logic        hold14, done14, err14, oob14;
  logic [14:0] wl14;
  logic        hold2, done2, err2, oob2;
  logic [2:0]  wl2;

  imem_load_ctrl_if #(.ADDR_W(14)) bus14 ();
  imem_load_ctrl_if #(.ADDR_W(2))  bus2 ();

  imem_load_ctrl #(.ADDR_W(14), .TIMEOUT_CYC(T), .CNT_W(5)) dut14 (
    .clock(clock), .reset(reset), .fetch_pc(fetch_pc), .load_start(load_start),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .imem(bus14), .cpu_hold(hold14),
    .load_done(done14), .load_err(err14), .words_loaded(wl14), .fetch_oob(oob14));

  imem_load_ctrl #(.ADDR_W(2), .TIMEOUT_CYC(T), .CNT_W(5)) dut2 (
    .clock(clock), .reset(reset), .fetch_pc(fetch_pc), .load_start(load_start),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .imem(bus2), .cpu_hold(hold2),
    .load_done(done2), .load_err(err2), .words_loaded(wl2), .fetch_oob(oob2));

  always #5 clock = ~clock;

  typedef struct { int addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] pc; int a14; bit o14; int a2; bit o2; } vec_t;

  wr_t         wq14[$];
  wr_t         wq2[$];
  logic [7:0]  bq[$];
  vec_t        vecs[7];
  int          ndone14 = 0, ndone2 = 0, dcyc14 = 0, dcyc2 = 0, cyc_no = 0, last_cyc = 0;
  int          n_chk = 0, n_pass = 0;

  always @(posedge clock) cyc_no <= cyc_no + 1;

  always @(negedge clock) begin
    if (bus14.imem_we) wq14.push_back('{int'(bus14.imem_addr), bus14.imem_wdata});
    if (bus2.imem_we)  wq2.push_back('{int'(bus2.imem_addr), bus2.imem_wdata});
    if (done14) begin ndone14 <= ndone14 + 1; dcyc14 <= cyc_no; end
    if (done2)  begin ndone2  <= ndone2 + 1;  dcyc2  <= cyc_no; end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    last_cyc = cyc_no;
    cyc();
    rx_valid = 1'b0;
  endtask

  // Reference: bytes group into words in arrival order at addresses 0,1,...;
  // filling the whole RAM or ending on a partial word flags an error.
  task automatic check_dut(input string nm, input int depth, input logic [7:0] bytes[$],
                           input wr_t wq[$], input int wl, input bit err, input int nd,
                           input int gap, input bit hold);
    int  n, nfull, exp_w;
    bit  wrap, exp_err;
    logic [31:0] w;
    n       = bytes.size();
    nfull   = n / 4;
    wrap    = (nfull >= depth);
    exp_w   = wrap ? depth : nfull;
    exp_err = wrap || (n % 4 != 0);
    chk({nm, " write_count"}, wq.size(), exp_w);
    for (int i = 0; i < wq.size() && i < exp_w; i++) begin
      w = {bytes[4*i], bytes[4*i+1], bytes[4*i+2], bytes[4*i+3]};
      chk({nm, " write_addr"}, wq[i].addr, i);
      chk({nm, " write_data"}, wq[i].data, w);
    end
    chk({nm, " words_loaded"}, wl, exp_w);
    chk({nm, " load_err"}, err, exp_err);
    chk({nm, " done_pulses"}, nd, 1);
    chk({nm, " cpu_hold_after"}, hold, 0);
    if (!wrap) chk({nm, " timeout_cycles"}, gap, T + 1);
  endtask

  task automatic run_load(input int gmax, input int pre_idle);
    int d14, d2, k;
    wq14.delete();
    wq2.delete();
    d14 = ndone14;
    d2  = ndone2;
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    @(negedge clock);
    chk("hold_in_load", hold14, 1);
    repeat (pre_idle) cyc();
    @(negedge clock);
    chk("no_timeout_before_first_byte", ndone14 - d14, 0);
    foreach (bq[i]) begin
      repeat ($urandom_range(0, gmax)) cyc();
      send(bq[i]);
    end
    k = 0;
    while ((ndone14 == d14 || ndone2 == d2) && k < T + 40) begin
      cyc();
      k++;
    end
    chk("done_within_bound", int'((ndone14 != d14) && (ndone2 != d2)), 1);
    repeat (2) cyc();
    @(negedge clock);
    check_dut("a14", 16384, bq, wq14, int'(wl14), err14, ndone14 - d14, dcyc14 - last_cyc, hold14);
    check_dut("a2", 4, bq, wq2, int'(wl2), err2, ndone2 - d2, dcyc2 - last_cyc, hold2);
  endtask

  initial begin
    int d, k;
    logic [31:0] pc;

    vecs[0] = '{32'h0000_0010, 4,       0, 0, 1};
    vecs[1] = '{32'h0000_0000, 0,       0, 0, 0};
    vecs[2] = '{32'h0000_000F, 3,       0, 3, 0};
    vecs[3] = '{32'h0000_FFFC, 'h3FFF,  0, 3, 1};
    vecs[4] = '{32'h0001_0000, 0,       1, 0, 1};
    vecs[5] = '{32'h0004_0000, 0,       1, 0, 1};
    vecs[6] = '{32'h8000_1235, 'h048D,  1, 1, 1};

    // reset state
    repeat (2) cyc();
    @(negedge clock);
    chk("rst cpu_hold", hold14, 0);
    chk("rst imem_we", bus14.imem_we, 0);
    chk("rst imem_wdata", bus14.imem_wdata, 0);
    chk("rst load_done", done14, 0);
    chk("rst load_err", err14, 0);
    chk("rst words_loaded", wl14, 0);
    chk("rst cpu_hold a2", hold2, 0);
    reset = 1'b0;
    cyc();

    // RUN address mapping table
    for (int i = 0; i < 7; i++) begin
      fetch_pc = vecs[i].pc;
      #1;
      chk("run addr14", bus14.imem_addr, vecs[i].a14);
      chk("run oob14", oob14, vecs[i].o14);
      chk("run addr2", bus2.imem_addr, vecs[i].a2);
      chk("run oob2", oob2, vecs[i].o2);
      chk("run we", bus14.imem_we, 0);
      chk("run hold", hold14, 0);
    end
    fetch_pc = 32'd0;

    // single word with exact write latency and done/hold timing
    wq14.delete();
    d = ndone14;
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    @(negedge clock);
    chk("lat imem_we", bus14.imem_we, 1);
    chk("lat imem_addr", bus14.imem_addr, 0);
    chk("lat imem_wdata", bus14.imem_wdata, 32'h1234_5678);
    chk("lat cpu_hold", hold14, 1);
    k = 0;
    while (!done14 && k < T + 10) begin
      @(negedge clock);
      k++;
    end
    chk("w1 done", done14, 1);
    chk("w1 hold_in_done", hold14, 1);
    chk("w1 words_loaded", wl14, 1);
    chk("w1 load_err", err14, 0);
    @(negedge clock);
    chk("w1 hold_falls", hold14, 0);
    chk("w1 done_one_cycle", done14, 0);
    chk("w1 write_count", wq14.size(), 1);

    // six bytes: one word plus a dropped partial
    bq.delete();
    for (int i = 0; i < 6; i++) bq.push_back(8'(8'hA0 + i));
    run_load(0, 0);

    // back-to-back bytes including during COMMIT
    bq.delete();
    for (int i = 0; i < 12; i++) bq.push_back(8'(8'h11 * (i + 1)));
    run_load(0, 0);

    // twenty bytes: the ADDR_W=2 build wraps after four words
    bq.delete();
    for (int i = 0; i < 20; i++) bq.push_back(8'(i + 1));
    run_load(0, 0);

    // long silence before the first byte must not time out
    bq.delete();
    for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
    run_load(0, 3 * T);

    // randomized streams
    for (int r = 0; r < 6; r++) begin
      bq.delete();
      k = $urandom_range(1, 22);
      for (int i = 0; i < k; i++) bq.push_back(8'($urandom));
      run_load(3, $urandom_range(0, 4));
    end

    // reset in the middle of a word
    d = ndone14;
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    send(8'hDE);
    send(8'hAD);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clock);
    chk("midrst cpu_hold", hold14, 0);
    chk("midrst load_done", done14, 0);
    chk("midrst words_loaded", wl14, 0);
    repeat (T + 5) cyc();
    chk("midrst no_done_pulse", ndone14 - d, 0);
    fetch_pc = 32'h0004_0000;
    #1;
    chk("midrst fetch_oob", oob14, 1);

    // random fetch addresses against arithmetic mapping
    for (int i = 0; i < 12; i++) begin
      pc = $urandom;
      if (i % 2 == 1) pc = pc & 32'h0000_FFFF;
      fetch_pc = pc;
      #1;
      chk("rnd addr14", bus14.imem_addr, (pc >> 2) & 32'h3FFF);
      chk("rnd oob14", oob14, int'((pc >> 16) != 0));
      chk("rnd addr2", bus2.imem_addr, (pc >> 2) & 32'h3);
      chk("rnd oob2", oob2, int'((pc >> 4) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
